// File: rtl/swap_pkg.sv
// Shared definitions for the swap-port register file and its initiators.
package swap_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 7;
   localparam int unsigned DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } swap_state_t;

endpackage : swap_pkg

// File: rtl/swap_region_reverser.sv
// Swap-port initiator that reverses an inclusive address range of the
// register file in place, one swap per non-stalled cycle.
// Optional feature: define SWAP_REGION_CNT_EN to add the swap_count output.
module swap_region_reverser
   import swap_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] lo_addr,
   input  logic [ADDR_WIDTH-1:0] hi_addr,
   input  logic                  stall,
   output logic [ADDR_WIDTH-1:0] address_A,
   output logic [ADDR_WIDTH-1:0] address_B,
   output logic                  swap,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err
`ifdef SWAP_REGION_CNT_EN
   ,
   output logic [ADDR_WIDTH-1:0] swap_count
`endif
);

   // The last-pair test compares against 2, so at least two address bits
   // are needed; the data width only has to be a real width.
   if (ADDR_WIDTH < 2 || DATA_WIDTH < 1) begin : g_bad_params
      $error("swap_region_reverser: ADDR_WIDTH must be >= 2 and DATA_WIDTH >= 1");
   end

   swap_state_t           state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr_a, ptr_b;
   logic [ADDR_WIDTH-1:0] ptr_diff;
   logic                  last_pair;
   logic                  accept;

   assign accept    = (state == IDLE) && start;
   // ptr_a < ptr_b always holds in RUN, so the unsigned difference cannot wrap.
   assign ptr_diff  = ptr_b - ptr_a;
   assign last_pair = (ptr_diff <= ADDR_WIDTH'(2));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (lo_addr < hi_addr) ? RUN : DONE;
            end
         end
         RUN: begin
            if (!stall && last_pair) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      swap      = (state == RUN) && !stall;
      busy      = (state == RUN);
      done      = (state == DONE);
      address_A = ptr_a;
      address_B = ptr_b;
   end

   // Pointers walk inward on every swap; range_err latches on accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_a     <= '0;
         ptr_b     <= '0;
         range_err <= 1'b0;
      end else begin
         if (accept) begin
            if (lo_addr < hi_addr) begin
               ptr_a     <= lo_addr;
               ptr_b     <= hi_addr;
               range_err <= 1'b0;
            end else begin
               range_err <= (lo_addr > hi_addr);
            end
         end else if (swap) begin
            ptr_a <= ptr_a + ADDR_WIDTH'(1);
            ptr_b <= ptr_b - ADDR_WIDTH'(1);
         end
      end
   end

`ifdef SWAP_REGION_CNT_EN
   // Swap counter: cleared on accepted start, holds after done
   always_ff @(posedge clk) begin
      if (reset) begin
         swap_count <= '0;
      end else if (accept) begin
         swap_count <= '0;
      end else if (swap) begin
         swap_count <= swap_count + ADDR_WIDTH'(1);
      end
   end
`endif

endmodule : swap_region_reverser

// File: tb/tb_swap_region_reverser.sv
// Self-checking bench for swap_region_reverser with a behavioural register
// file that applies the DUT's swaps.
module tb_swap_region_reverser;
   import swap_pkg::*;

   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, start, stall;
   logic [AW-1:0] lo_addr, hi_addr;
   logic [AW-1:0] address_A, address_B;
   logic          swap, busy, done, range_err;
`ifdef SWAP_REGION_CNT_EN
   logic [AW-1:0] swap_count;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [7:0] mem     [DEPTH];
   logic [7:0] exp_mem [DEPTH];
   logic       load;
   logic [7:0] load_salt;

   always #5 clk = ~clk;

   swap_region_reverser #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .lo_addr   (lo_addr),
      .hi_addr   (hi_addr),
      .stall     (stall),
      .address_A (address_A),
      .address_B (address_B),
      .swap      (swap),
      .busy      (busy),
      .done      (done),
      .range_err (range_err)
`ifdef SWAP_REGION_CNT_EN
      ,
      .swap_count(swap_count)
`endif
   );

   // Register file model: preload pattern, or swap two words on swap=1.
   // A swap coinciding with reset is treated as not taken.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) ^ load_salt;
      end else if (swap && !reset) begin
         mem[address_A] <= mem[address_B];
         mem[address_B] <= mem[address_A];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] salt);
      load_salt = salt;
      load      = 1'b1;
      tick();
      load      = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
      check(tag, bad, 0);
   endtask

   // One complete operation; called at posedge+1 with the DUT idle.
   task automatic run_op(input int lo, input int hi, input int stall_pct,
                         input bit poke_start, input int hold_after_first);
      int qa[$];
      int qb[$];
      int n_exp, nsw, hold;
      bit got_done, expect_done;
      // Reference: reversed range, pairs taken from both ends inward
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
      n_exp = (lo <= hi) ? (hi - lo + 1) / 2 : 0;
      for (int i = 0; i < n_exp; i++) begin
         qa.push_back(lo + i);
         qb.push_back(hi - i);
      end
      if (lo <= hi)
         for (int i = 0; i <= hi - lo; i++) exp_mem[lo + i] = mem[hi - i];

      start   = 1'b1;
      lo_addr = AW'(lo);
      hi_addr = AW'(hi);
      stall   = 1'b0;
      tick();
      start       = 1'b0;
      nsw         = 0;
      hold        = hold_after_first;
      got_done    = 1'b0;
      expect_done = 1'b0;
      for (int cyc = 0; cyc < 1000 && !got_done; cyc++) begin
         if (nsw == 1 && hold > 0) begin
            stall = 1'b1;
            hold--;
         end else begin
            stall = ($urandom_range(99) < stall_pct);
         end
         if (poke_start) begin
            start   = 1'($urandom_range(1));
            lo_addr = AW'($urandom);
            hi_addr = AW'($urandom);
         end
         #1;
`ifdef SWAP_REGION_CNT_EN
         check("swap_count", swap_count, nsw);
`endif
         if (expect_done) check("done_after_last", done, 1);
         if (done) begin
            got_done = 1'b1;
            check("no_pairs_left", qa.size(), 0);
            check("range_err_at_done", range_err, lo > hi);
            check("busy_in_done", busy, 0);
         end else begin
            check("busy", busy, 1);
            check("swap_vs_stall", swap, !stall);
            if (swap) begin
               check("pair_available", qa.size() > 0, 1);
               if (qa.size() > 0) begin
                  check("address_A", address_A, qa.pop_front());
                  check("address_B", address_B, qb.pop_front());
               end
               nsw++;
               if (qa.size() == 0) expect_done = 1'b1;
            end else begin
               check("hold_A", address_A, lo + nsw);
               check("hold_B", address_B, hi - nsw);
            end
         end
         tick();
      end
      start = 1'b0;
      stall = 1'b0;
      check("done_seen", got_done, 1);
      check("swap_total", nsw, n_exp);
      check("done_pulse_len", done, 0);
      check("idle_busy", busy, 0);
      check("idle_swap", swap, 0);
      check("range_err_held", range_err, lo > hi);
`ifdef SWAP_REGION_CNT_EN
      check("swap_count_final", swap_count, n_exp);
`endif
      check_mem("mem_contents");
   endtask

   initial begin
      int lo, hi;
      reset     = 1'b1;
      start     = 1'b0;
      stall     = 1'b0;
      lo_addr   = '0;
      hi_addr   = '0;
      load      = 1'b0;
      load_salt = '0;
      repeat (2) tick();
      check("rst_A", address_A, 0);
      check("rst_B", address_B, 0);
      check("rst_swap", swap, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_range_err", range_err, 0);
      reset = 1'b0;
      tick();

      preload(8'h00);  run_op(22, 28, 0, 1'b0, 0);
      preload(8'h00);  run_op(20, 29, 0, 1'b0, 0);
      run_op(5, 5, 0, 1'b0, 0);
      run_op(9, 3, 0, 1'b0, 0);
      preload(8'h00);  run_op(22, 28, 0, 1'b0, 4);
      preload(8'h00);  run_op(22, 28, 0, 1'b1, 0);
      preload(8'h5a);  run_op(0, DEPTH - 1, 0, 1'b0, 0);
      preload(8'h33);  run_op(0, DEPTH - 1, 30, 1'b0, 0);

      // Reset during the second swap: only the first pair is exchanged
      preload(8'h00);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
      exp_mem[22] = mem[28];
      exp_mem[28] = mem[22];
      start   = 1'b1;
      lo_addr = AW'(22);
      hi_addr = AW'(28);
      tick();
      start = 1'b0;
      #1;
      check("rst_mid_first_A", address_A, 22);
      tick();
      check("rst_mid_second_A", address_A, 23);
      check("rst_mid_second_B", address_B, 27);
      check("rst_mid_second_swap", swap, 1);
      reset = 1'b1;
      tick();
      check("rst_mid_swap", swap, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_A", address_A, 0);
      check("rst_mid_B", address_B, 0);
      check("rst_mid_range_err", range_err, 0);
      reset = 1'b0;
      tick();
      check("rst_mid_idle_busy", busy, 0);
      check_mem("rst_mid_mem");

      repeat (30) begin
         preload(8'($urandom));
         lo = $urandom_range(DEPTH - 1);
         hi = $urandom_range(DEPTH - 1);
         run_op(lo, hi, $urandom_range(40), 1'($urandom_range(1)), $urandom_range(3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_swap_region_reverser
